// File: rtl/width_downsizer.sv
// width_downsizer: splits each IN_W-bit word into RATIO = IN_W/OUT_W narrow beats.
// Define WIDTH_DOWNSIZER_MSB_ONLY_EN to emit only the top OUT_W bits of each word.
module width_downsizer #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  generate
    if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : g_bad_ratio
      $error("width_downsizer: IN_W must be a multiple of OUT_W with a ratio of at least 2");
    end
  endgenerate

  typedef enum logic {
    EMPTY,
    SEND
  } state_t;

  state_t           state;
  logic [IN_W-1:0]  hold;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             beat_done;
  logic             capture;

  function automatic logic [OUT_W-1:0] slice_of(input logic [IN_W-1:0] word,
                                                input logic [CNT_W-1:0] k);
    int base;
    if (MSB_FIRST) base = IN_W - OUT_W * (int'(k) + 1);
    else           base = OUT_W * int'(k);
    return word[base +: OUT_W];
  endfunction

  assign beat_done = m_valid && m_ready;
  assign next_cnt  = cnt + 1'b1;
  // The final-beat handshake frees the hold register in the same cycle, so a new word can enter.
  assign s_ready   = !rst && (state == EMPTY || (beat_done && m_last));
  assign capture   = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the hold register is reset too, so no stale data survives a mid-word reset.
      state   <= EMPTY;
      hold    <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (capture) begin
      state   <= SEND;
      hold    <= s_data;
      cnt     <= '0;
      m_valid <= 1'b1;
`ifdef WIDTH_DOWNSIZER_MSB_ONLY_EN
      m_data  <= s_data[IN_W-1 -: OUT_W];
      m_last  <= 1'b1;
`else
      m_data  <= slice_of(s_data, '0);
      m_last  <= 1'b0;
`endif
    end else if (beat_done) begin
      if (m_last) begin
        state   <= EMPTY;
        m_valid <= 1'b0;
      end else begin
        cnt    <= next_cnt;
        m_data <= slice_of(hold, next_cnt);
        m_last <= (next_cnt == CNT_W'(RATIO - 1));
      end
    end
  end

endmodule

// File: tb/tb_width_downsizer.sv
// Directed bench for width_downsizer: 16->8 MSB-first and 32->8 LSB-first instances.
// Expectations follow WIDTH_DOWNSIZER_MSB_ONLY_EN when the bench is built with it.
module tb_width_downsizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [15:0] s_data_a  = '0;
  logic        s_valid_a = 1'b0;
  logic        s_ready_a;
  logic [7:0]  m_data_a;
  logic        m_valid_a;
  logic        m_ready_a = 1'b1;
  logic        m_last_a;

  logic [31:0] s_data_b  = '0;
  logic        s_valid_b = 1'b0;
  logic        s_ready_b;
  logic [7:0]  m_data_b;
  logic        m_valid_b;
  logic        m_ready_b = 1'b1;
  logic        m_last_b;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       last;
    logic       sr;
  } beat_t;

  beat_t q_a[$];
  beat_t q_b[$];

  typedef struct {
    logic [15:0] word;
    int          stall;
    int          n_beats;
    logic [7:0]  exp0;
    logic [7:0]  exp1;
  } vec_t;

  vec_t vecs[5];

  width_downsizer #(.IN_W(16), .OUT_W(8), .MSB_FIRST(1'b1)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data_a),
    .s_valid (s_valid_a),
    .s_ready (s_ready_a),
    .m_data  (m_data_a),
    .m_valid (m_valid_a),
    .m_ready (m_ready_a),
    .m_last  (m_last_a)
  );

  width_downsizer #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b0)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data_b),
    .s_valid (s_valid_b),
    .s_ready (s_ready_b),
    .m_data  (m_data_b),
    .m_valid (m_valid_b),
    .m_ready (m_ready_b),
    .m_last  (m_last_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Beats are logged half a cycle before the edge that completes their handshake.
  always @(negedge clk) begin
    if (!rst && m_valid_a && m_ready_a) q_a.push_back('{cyc, m_data_a, m_last_a, s_ready_a});
    if (!rst && m_valid_b && m_ready_b) q_b.push_back('{cyc, m_data_b, m_last_b, s_ready_b});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put_a(input logic [15:0] w, input bit keep_valid);
    int n = 0;
    s_data_a  = w;
    s_valid_a = 1'b1;
    @(negedge clk);
    while (!s_ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_a_in_time", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    if (!keep_valid) s_valid_a = 1'b0;
  endtask

  task automatic put_b(input logic [31:0] w);
    int n = 0;
    s_data_b  = w;
    s_valid_b = 1'b1;
    @(negedge clk);
    while (!s_ready_b && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_b_in_time", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    s_valid_b = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b2b_data[4];
    logic       b2b_last[4];
    logic       b2b_sr[4];
    int         b2b_n;
    logic [7:0] lsb_data[4];
    logic       lsb_last[4];
    int         lsb_n;

`ifdef WIDTH_DOWNSIZER_MSB_ONLY_EN
    vecs[0] = '{16'hA55A, 0, 1, 8'hA5, 8'h00};
    vecs[1] = '{16'h1234, 0, 1, 8'h12, 8'h00};
    vecs[2] = '{16'hFF00, 0, 1, 8'hFF, 8'h00};
    vecs[3] = '{16'hA55A, 3, 1, 8'hA5, 8'h00};
    vecs[4] = '{16'h00FF, 0, 1, 8'h00, 8'h00};
    b2b_n = 2;
    b2b_data = '{8'h12, 8'hAB, 8'h00, 8'h00};
    b2b_last = '{1'b1, 1'b1, 1'b0, 1'b0};
    b2b_sr   = '{1'b1, 1'b1, 1'b0, 1'b0};
    lsb_n = 1;
    lsb_data = '{8'h11, 8'h00, 8'h00, 8'h00};
    lsb_last = '{1'b1, 1'b0, 1'b0, 1'b0};
`else
    vecs[0] = '{16'hA55A, 0, 2, 8'hA5, 8'h5A};
    vecs[1] = '{16'h1234, 0, 2, 8'h12, 8'h34};
    vecs[2] = '{16'hFF00, 0, 2, 8'hFF, 8'h00};
    vecs[3] = '{16'hA55A, 3, 2, 8'hA5, 8'h5A};
    vecs[4] = '{16'h00FF, 0, 2, 8'h00, 8'hFF};
    b2b_n = 4;
    b2b_data = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    b2b_last = '{1'b0, 1'b1, 1'b0, 1'b1};
    b2b_sr   = '{1'b0, 1'b1, 1'b0, 1'b1};
    lsb_n = 4;
    lsb_data = '{8'h44, 8'h33, 8'h22, 8'h11};
    lsb_last = '{1'b0, 1'b0, 1'b0, 1'b1};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_s_ready", 32'(s_ready_a), 32'd0);
    check("rst_m_valid", 32'(m_valid_a), 32'd0);
    check("rst_m_data",  32'(m_data_a),  32'd0);
    check("rst_m_last",  32'(m_last_a),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", 32'(s_ready_a), 32'd1);
    check("post_rst_m_valid", 32'(m_valid_a), 32'd0);
    @(posedge clk);
    #1;

    // Single word, first beat one cycle after accept
    put_a(16'hA55A, 1'b0);
    @(negedge clk);
    check("first_m_valid", 32'(m_valid_a), 32'd1);
    check("first_m_data",  32'(m_data_a),  32'hA5);
`ifdef WIDTH_DOWNSIZER_MSB_ONLY_EN
    check("first_m_last",  32'(m_last_a),  32'd1);
    check("first_s_ready", 32'(s_ready_a), 32'd1);
`else
    check("first_m_last",  32'(m_last_a),  32'd0);
    check("first_s_ready", 32'(s_ready_a), 32'd0);
    @(negedge clk);
    check("second_m_data", 32'(m_data_a),  32'h5A);
    check("second_m_last", 32'(m_last_a),  32'd1);
    check("second_s_ready", 32'(s_ready_a), 32'd1);
`endif
    @(negedge clk);
    check("idle_m_valid", 32'(m_valid_a), 32'd0);
    drain(1);

    // Table of single words, some with a downstream stall on the first beat
    foreach (vecs[i]) begin
      q_a.delete();
      m_ready_a = (vecs[i].stall == 0);
      put_a(vecs[i].word, 1'b0);
      for (int s = 0; s < vecs[i].stall; s++) begin
        @(negedge clk);
        check("stall_m_valid", 32'(m_valid_a), 32'd1);
        check("stall_m_data",  32'(m_data_a),  32'(vecs[i].exp0));
        check("stall_s_ready", 32'(s_ready_a), 32'd0);
      end
      if (vecs[i].stall != 0) begin
        @(posedge clk);
        #1;
        m_ready_a = 1'b1;
      end
      drain(4);
      check("vec_beat_count", 32'(q_a.size()), 32'(vecs[i].n_beats));
      if (q_a.size() == vecs[i].n_beats) begin
        check("vec_beat0_data", 32'(q_a[0].data), 32'(vecs[i].exp0));
        check("vec_beat0_last", 32'(q_a[0].last), 32'(vecs[i].n_beats == 1));
        if (vecs[i].n_beats == 2) begin
          check("vec_beat1_data", 32'(q_a[1].data), 32'(vecs[i].exp1));
          check("vec_beat1_last", 32'(q_a[1].last), 32'd1);
          check("vec_beat1_cyc",  32'(q_a[1].cyc - q_a[0].cyc), 32'd1);
        end
      end
    end

    // Back-to-back words with s_valid and m_ready held high
    q_a.delete();
    m_ready_a = 1'b1;
    put_a(16'h1234, 1'b1);
    put_a(16'hABCD, 1'b0);
    drain(5);
    check("b2b_beat_count", 32'(q_a.size()), 32'(b2b_n));
    if (q_a.size() == b2b_n) begin
      for (int i = 0; i < b2b_n; i++) begin
        check("b2b_data",    32'(q_a[i].data), 32'(b2b_data[i]));
        check("b2b_last",    32'(q_a[i].last), 32'(b2b_last[i]));
        check("b2b_s_ready", 32'(q_a[i].sr),   32'(b2b_sr[i]));
        check("b2b_cyc",     32'(q_a[i].cyc - q_a[0].cyc), 32'(i));
      end
    end

    // LSB-first 32->8 instance
    m_ready_b = 1'b1;
    put_b(32'h11223344);
    drain(6);
    check("lsb_beat_count", 32'(q_b.size()), 32'(lsb_n));
    if (q_b.size() == lsb_n) begin
      for (int i = 0; i < lsb_n; i++) begin
        check("lsb_data", 32'(q_b[i].data), 32'(lsb_data[i]));
        check("lsb_last", 32'(q_b[i].last), 32'(lsb_last[i]));
        check("lsb_cyc",  32'(q_b[i].cyc - q_b[0].cyc), 32'(i));
      end
    end

    // Asynchronous reset after the first beat of 0xA55A
    q_a.delete();
    m_ready_a = 1'b1;
    put_a(16'hA55A, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_m_valid", 32'(m_valid_a), 32'd0);
    check("async_rst_m_data",  32'(m_data_a),  32'd0);
    check("async_rst_m_last",  32'(m_last_a),  32'd0);
    check("async_rst_s_ready", 32'(s_ready_a), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_s_ready", 32'(s_ready_a), 32'd1);
    check("rel_m_valid", 32'(m_valid_a), 32'd0);
    drain(3);
    check("rst_beat_count", 32'(q_a.size()), 32'd1);
    if (q_a.size() == 1) check("rst_beat_data", 32'(q_a[0].data), 32'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
